// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for IF-stage next-PC selection.
// ID-stage feedback trains the table, flags mispredicts and keeps perf counters.
module branch_predictor #(
    parameter int         ADDR_W   = 32,
    parameter int         ENTRIES  = 64,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         PERF_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              predict_hit_o,
    output logic              predict_taken_o,
    output logic [ADDR_W-1:0] predict_target_o,
    input  logic              update_valid_i,
    input  logic [ADDR_W-1:0] update_pc_i,
    input  logic              update_taken_i,
    input  logic [ADDR_W-1:0] update_target_i,
    input  logic              update_pred_taken_i,
    input  logic [ADDR_W-1:0] update_pred_target_i,
    output logic              mispredict_o,
    output logic [PERF_W-1:0] branch_cnt_o,
    output logic [PERF_W-1:0] mispred_cnt_o
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [ENTRIES];
    logic [ADDR_W-1:0]  r_tgt [ENTRIES];
    logic [1:0]         r_cnt [ENTRIES];
    logic [PERF_W-1:0]  r_branch_cnt;
    logic [PERF_W-1:0]  r_mispred_cnt;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_en;

    assign w_lk_idx = lookup_pc_i[IDX_W+1:2];
    assign w_lk_tag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign w_up_idx = update_pc_i[IDX_W+1:2];
    assign w_up_tag = update_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    assign predict_hit_o    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign predict_taken_o  = start_i && predict_hit_o && r_cnt[w_lk_idx][1];
    assign predict_target_o = predict_taken_o ? r_tgt[w_lk_idx] : lookup_pc_i + ADDR_W'(4);

    assign w_up_en  = update_valid_i && start_i;
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // A taken branch with the right direction can still redirect wrongly via its target.
    assign mispredict_o = w_up_en &&
        ((update_pred_taken_i != update_taken_i) ||
         (update_taken_i && update_pred_taken_i && (update_pred_target_i != update_target_i)));

    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid       <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT;
        end else if (w_up_en) begin
            if (w_up_hit) begin
                if (update_taken_i) begin
                    r_tgt[w_up_idx] <= update_target_i;
                    if (r_cnt[w_up_idx] != 2'b11) r_cnt[w_up_idx] <= r_cnt[w_up_idx] + 2'b01;
                end else if (r_cnt[w_up_idx] != 2'b00) begin
                    r_cnt[w_up_idx] <= r_cnt[w_up_idx] - 2'b01;
                end
            end else if (update_taken_i) begin
                // Only taken branches earn a slot; a miss replaces whatever aliased there.
                r_valid[w_up_idx] <= 1'b1;
                r_tag[w_up_idx]   <= w_up_tag;
                r_tgt[w_up_idx]   <= update_target_i;
                r_cnt[w_up_idx]   <= 2'b10;
            end
            if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (mispredict_o && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, saturation, aliasing, reset and start gating.
module tb_branch_predictor;
    localparam int AW = 32;
    localparam int PW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] lookup_pc_i;
    logic          predict_hit_o;
    logic          predict_taken_o;
    logic [AW-1:0] predict_target_o;
    logic          update_valid_i;
    logic [AW-1:0] update_pc_i;
    logic          update_taken_i;
    logic [AW-1:0] update_target_i;
    logic          update_pred_taken_i;
    logic [AW-1:0] update_pred_target_i;
    logic          mispredict_o;
    logic [PW-1:0] branch_cnt_o;
    logic [PW-1:0] mispred_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor #(.ADDR_W(AW), .ENTRIES(64), .TAG_W(8), .CNT_INIT(2'b01), .PERF_W(PW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .lookup_pc_i(lookup_pc_i),
        .predict_hit_o(predict_hit_o), .predict_taken_o(predict_taken_o),
        .predict_target_o(predict_target_o), .update_valid_i(update_valid_i),
        .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
        .update_target_i(update_target_i), .update_pred_taken_i(update_pred_taken_i),
        .update_pred_target_i(update_pred_target_i), .mispredict_o(mispredict_o),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic lk(input logic [AW-1:0] pc, input logic hit, input logic tk,
                      input logic [AW-1:0] tgt, input string tag);
        lookup_pc_i = pc;
        #1;
        chk({tag, ".hit"}, 64'(predict_hit_o), 64'(hit));
        chk({tag, ".taken"}, 64'(predict_taken_o), 64'(tk));
        chk({tag, ".target"}, 64'(predict_target_o), 64'(tgt));
    endtask

    task automatic upd(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tgt,
                       input logic ptk, input logic [AW-1:0] ptgt);
        update_valid_i       = 1'b1;
        update_pc_i          = pc;
        update_taken_i       = tk;
        update_target_i      = tgt;
        update_pred_taken_i  = ptk;
        update_pred_target_i = ptgt;
        #1;
    endtask

    task automatic idle();
        update_valid_i = 1'b0;
        update_taken_i = 1'b0;
        update_pred_taken_i = 1'b0;
        #1;
    endtask

    task automatic cnts(input int b, input int m, input string tag);
        chk({tag, ".bcnt"}, 64'(branch_cnt_o), 64'(b));
        chk({tag, ".mcnt"}, 64'(mispred_cnt_o), 64'(m));
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b1; lookup_pc_i = '0;
        update_valid_i = 1'b0; update_pc_i = '0; update_taken_i = 1'b0;
        update_target_i = '0; update_pred_taken_i = 1'b0; update_pred_target_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        lk(32'h40, 1'b0, 1'b0, 32'h44, "rst_lk");
        cnts(0, 0, "rst");

        // First taken allocates with cnt=10
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        chk("alloc_mispred", 64'(mispredict_o), 64'd1);
        tick(); idle();
        lk(32'h40, 1'b1, 1'b1, 32'h100, "alloc");
        cnts(1, 1, "alloc");

        // Not-taken x3: 10->01->00->00
        for (int i = 0; i < 3; i++) begin
            upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("nt_mispred", 64'(mispredict_o), 64'd0);
            tick(); idle();
            lk(32'h40, 1'b1, 1'b0, 32'h44, $sformatf("nt%0d", i));
        end
        // Taken x3: 00->01->10->11
        for (int i = 0; i < 3; i++) begin
            upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            chk("tk_mispred", 64'(mispredict_o), 64'd0);
            tick(); idle();
            lk(32'h40, 1'b1, (i >= 1), (i >= 1) ? 32'h100 : 32'h44, $sformatf("tk%0d", i));
        end
        cnts(7, 1, "train");
        // Stay at 11, then one not-taken leaves 10 (still taken)
        upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); tick();
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0); tick(); idle();
        lk(32'h40, 1'b1, 1'b1, 32'h100, "sat_hi");
        cnts(9, 1, "sat");

        // Same-cycle lookup sees old target; also a target mispredict
        lookup_pc_i = 32'h40;
        upd(32'h40, 1'b1, 32'h300, 1'b1, 32'h100);
        chk("rbw_old", 64'(predict_target_o), 64'h100);
        chk("tgt_mispred", 64'(mispredict_o), 64'd1);
        tick(); idle();
        lk(32'h40, 1'b1, 1'b1, 32'h300, "rbw_new");
        cnts(10, 2, "rbw");

        // Alias 0x1040 onto index 16
        lk(32'h1040, 1'b0, 1'b0, 32'h1044, "alias_miss");
        upd(32'h1040, 1'b1, 32'h200, 1'b0, 32'h0);
        chk("alias_mispred", 64'(mispredict_o), 64'd1);
        tick(); idle();
        lk(32'h40, 1'b0, 1'b0, 32'h44, "alias_old");
        lk(32'h1040, 1'b1, 1'b1, 32'h200, "alias_new");

        // Not-taken miss does not allocate
        upd(32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ntmiss_mispred", 64'(mispredict_o), 64'd0);
        tick(); idle();
        lk(32'h80, 1'b0, 1'b0, 32'h84, "ntmiss");
        cnts(12, 3, "ntmiss");
        lk(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, "wrap");

        // start_i low: hit reported, no prediction, no state change
        start_i = 1'b0;
        lk(32'h1040, 1'b1, 1'b0, 32'h1044, "stop_lk");
        upd(32'h1040, 1'b0, 32'h0, 1'b1, 32'h200);
        chk("stop_mispred", 64'(mispredict_o), 64'd0);
        tick(); tick(); idle();
        start_i = 1'b1;
        lk(32'h1040, 1'b1, 1'b1, 32'h200, "stop_after");
        cnts(12, 3, "stop");

        // Perf counters saturate at all-ones
        for (int i = 0; i < 5; i++) begin
            upd(32'h1040, 1'b1, 32'h200, 1'b0, 32'h0);
            tick();
        end
        idle();
        cnts(15, 8, "perf_sat");

        // Reset with an update pending: output from pre-reset state, update discarded
        rst_i = 1'b1;
        lookup_pc_i = 32'h1040;
        upd(32'h80, 1'b1, 32'h400, 1'b0, 32'h0);
        chk("rst_pre_hit", 64'(predict_hit_o), 64'd1);
        tick();
        rst_i = 1'b0;
        idle();
        lk(32'h80, 1'b0, 1'b0, 32'h84, "rst2_80");
        lk(32'h1040, 1'b0, 1'b0, 32'h1044, "rst2_1040");
        cnts(0, 0, "rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
